// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared types and helpers for the FPU compare path.
//                - fcmp_op_t : operation codes of the compare unit
//                - fcmp_qnan : canonical quiet-NaN pattern {0, all ones, 1, 0..}
//                              for a given exponent/mantissa width, returned
//                              right-aligned in a c_QNAN_MAX_W-bit vector.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [2:0] {
        FCMP_EQ  = 3'd0,
        FCMP_LT  = 3'd1,
        FCMP_LE  = 3'd2,
        FCMP_GE  = 3'd3,
        FCMP_MIN = 3'd4,
        FCMP_MAX = 3'd5
    } fcmp_op_t;

    localparam int c_QNAN_MAX_W = 128;

    // Caller slices the low 1+exp_w+man_w bits.
    function automatic logic [c_QNAN_MAX_W-1:0] fcmp_qnan(input int exp_w, input int man_w);
        logic [c_QNAN_MAX_W-1:0] v;
        v = ((c_QNAN_MAX_W'(1) << exp_w) - c_QNAN_MAX_W'(1)) << man_w;
        v = v | (c_QNAN_MAX_W'(1) << (man_w - 1));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fcmp_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_pipe_if
//  Description : Handshake bundle of the pipelined FP compare unit.
//                Input side : in_valid/in_ready, in_op, in_x1, in_x2, in_tag
//                Output side: out_valid/out_ready, out_flag, out_result, out_tag
//                modport master : producer/consumer (testbench, issue logic)
//                modport slave  : the compare unit itself
//  Revision    : 1.0  initial release
// ============================================================================
interface fcmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [W-1:0]     in_x1;
    logic [W-1:0]     in_x2;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_flag;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_flag, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_flag, out_result, out_tag
    );

endinterface
`default_nettype wire

// File: rtl/fcmp_core.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_core
//  Description : Combinational operand decode and ordering.
//                x1, x2 : operands {sign, exponent, mantissa}
//                eq     : operands equal
//                ge     : x1 >= x2
//                With FCMP_NAN_EN defined, also:
//                nan1, nan2 : operand is a NaN
//                zeros      : both operands are zero (either sign)
//                and +0/-0 are folded into eq/ge as equal.
//  Revision    : 1.0  initial release
// ============================================================================
module fcmp_core #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  wire logic [W-1:0] x1,
    input  wire logic [W-1:0] x2,
    output logic              eq,
    output logic              ge
`ifdef FCMP_NAN_EN
    ,
    output logic              nan1,
    output logic              nan2,
    output logic              zeros
`endif
);

    logic         w_s1;
    logic         w_s2;
    logic [W-2:0] w_mag1;
    logic [W-2:0] w_mag2;
    logic         w_ge_sm;
    logic         w_eq_bits;

    assign w_s1      = x1[W-1];
    assign w_s2      = x2[W-1];
    assign w_mag1    = x1[W-2:0];
    assign w_mag2    = x2[W-2:0];
    assign w_eq_bits = (x1 == x2);

    // Sign-magnitude order; for two negatives the larger magnitude is smaller.
    always_comb begin
        case ({w_s1, w_s2})
            2'b00:   w_ge_sm = (w_mag1 >= w_mag2);
            2'b01:   w_ge_sm = 1'b1;
            2'b10:   w_ge_sm = 1'b0;
            default: w_ge_sm = (w_mag1 <= w_mag2);
        endcase
    end

`ifdef FCMP_NAN_EN
    assign zeros = (w_mag1 == '0) && (w_mag2 == '0);
    assign nan1  = (x1[W-2 -: EXP_W] == '1) && (x1[MAN_W-1:0] != '0);
    assign nan2  = (x2[W-2 -: EXP_W] == '1) && (x2[MAN_W-1:0] != '0);
    assign eq    = w_eq_bits | zeros;
    assign ge    = w_ge_sm   | zeros;
`else
    assign eq    = w_eq_bits;
    assign ge    = w_ge_sm;
`endif

endmodule
`default_nettype wire

// File: rtl/fcmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_pipe
//  Description : Pipelined floating-point compare unit (EQ/LT/LE/GE/MIN/MAX).
//                clk, rst : clock, synchronous active-high reset
//                bus      : fcmp_pipe_if.slave handshake bundle
//                           in_*  : operation, operands, tag  (valid/ready)
//                           out_* : flag, result word, tag    (valid/ready)
//                LATENCY=2: stage 1 holds decoded compare bits + operands,
//                           stage 2 holds the selected flag/result.
//                LATENCY=1: decode and select feed the output register.
//                Optional macro FCMP_NAN_EN: IEEE zero equality and NaN
//                handling; when undefined, pure sign-magnitude ordering.
//  Revision    : 1.0  initial release
// ============================================================================
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  wire logic  clk,
    input  wire logic  rst,
    fcmp_pipe_if.slave bus
);

    localparam int W = 1 + EXP_W + MAN_W;

`ifdef FCMP_NAN_EN
    localparam logic [c_QNAN_MAX_W-1:0] c_QNAN_FULL = fcmp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]            c_QNAN      = c_QNAN_FULL[W-1:0];
`endif

    if ((LATENCY != 1) && (LATENCY != 2)) begin : g_bad_latency
        $error("fcmp_pipe: LATENCY must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // Decode of the incoming operands
    // ------------------------------------------------------------------
    logic w_c_eq;
    logic w_c_ge;
`ifdef FCMP_NAN_EN
    logic w_c_nan1;
    logic w_c_nan2;
    logic w_c_zeros;
`endif

    fcmp_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .x1    (bus.in_x1),
        .x2    (bus.in_x2),
        .eq    (w_c_eq),
        .ge    (w_c_ge)
`ifdef FCMP_NAN_EN
        ,
        .nan1  (w_c_nan1),
        .nan2  (w_c_nan2),
        .zeros (w_c_zeros)
`endif
    );

    // Every stage shifts together whenever the output slot is free.
    logic w_advance;
    assign w_advance    = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = w_advance;

    // ------------------------------------------------------------------
    // View feeding the select logic: stage-1 registers or live inputs
    // ------------------------------------------------------------------
    logic             w_v_valid;
    logic [2:0]       w_v_op;
    logic [W-1:0]     w_v_x1;
    logic [W-1:0]     w_v_x2;
    logic [TAG_W-1:0] w_v_tag;
    logic             w_v_eq;
    logic             w_v_ge;
`ifdef FCMP_NAN_EN
    logic             w_v_nan1;
    logic             w_v_nan2;
    logic             w_v_zeros;
`endif

    if (LATENCY == 1) begin : g_lat1
        assign w_v_valid = bus.in_valid;
        assign w_v_op    = bus.in_op;
        assign w_v_x1    = bus.in_x1;
        assign w_v_x2    = bus.in_x2;
        assign w_v_tag   = bus.in_tag;
        assign w_v_eq    = w_c_eq;
        assign w_v_ge    = w_c_ge;
`ifdef FCMP_NAN_EN
        assign w_v_nan1  = w_c_nan1;
        assign w_v_nan2  = w_c_nan2;
        assign w_v_zeros = w_c_zeros;
`endif
    end else begin : g_lat2
        logic             r1_valid;
        logic [2:0]       r1_op;
        logic [W-1:0]     r1_x1;
        logic [W-1:0]     r1_x2;
        logic [TAG_W-1:0] r1_tag;
        logic             r1_eq;
        logic             r1_ge;
`ifdef FCMP_NAN_EN
        logic             r1_nan1;
        logic             r1_nan2;
        logic             r1_zeros;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r1_valid <= 1'b0;
                r1_op    <= '0;
                r1_x1    <= '0;
                r1_x2    <= '0;
                r1_tag   <= '0;
                r1_eq    <= 1'b0;
                r1_ge    <= 1'b0;
`ifdef FCMP_NAN_EN
                r1_nan1  <= 1'b0;
                r1_nan2  <= 1'b0;
                r1_zeros <= 1'b0;
`endif
            end else if (w_advance) begin
                r1_valid <= bus.in_valid;
                r1_op    <= bus.in_op;
                r1_x1    <= bus.in_x1;
                r1_x2    <= bus.in_x2;
                r1_tag   <= bus.in_tag;
                r1_eq    <= w_c_eq;
                r1_ge    <= w_c_ge;
`ifdef FCMP_NAN_EN
                r1_nan1  <= w_c_nan1;
                r1_nan2  <= w_c_nan2;
                r1_zeros <= w_c_zeros;
`endif
            end
        end

        assign w_v_valid = r1_valid;
        assign w_v_op    = r1_op;
        assign w_v_x1    = r1_x1;
        assign w_v_x2    = r1_x2;
        assign w_v_tag   = r1_tag;
        assign w_v_eq    = r1_eq;
        assign w_v_ge    = r1_ge;
`ifdef FCMP_NAN_EN
        assign w_v_nan1  = r1_nan1;
        assign w_v_nan2  = r1_nan2;
        assign w_v_zeros = r1_zeros;
`endif
    end

    // ------------------------------------------------------------------
    // Flag / result selection
    // ------------------------------------------------------------------
    logic         w_le;
    logic         w_min_x1;
    logic         w_max_x1;
    logic         w_flag;
    logic [W-1:0] w_result;

    assign w_le = ~w_v_ge | w_v_eq;

`ifdef FCMP_NAN_EN
    // For a +0/-0 pair the compare bits say "equal", but MIN must yield -0
    // and MAX +0, so the choice falls back to the raw sign bits.
    assign w_min_x1 = w_v_zeros ? (w_v_x1[W-1] | ~w_v_x2[W-1]) : w_le;
    assign w_max_x1 = w_v_zeros ? (~w_v_x1[W-1] | w_v_x2[W-1]) : w_v_ge;
`else
    assign w_min_x1 = w_le;
    assign w_max_x1 = w_v_ge;
`endif

    always_comb begin
        w_flag   = 1'b0;
        w_result = '0;
        case (w_v_op)
            FCMP_EQ:  w_flag = w_v_eq;
            FCMP_LT:  w_flag = ~w_v_ge;
            FCMP_LE:  w_flag = w_le;
            FCMP_GE:  w_flag = w_v_ge;
            FCMP_MIN: begin
                w_flag   = w_min_x1;
                w_result = w_min_x1 ? w_v_x1 : w_v_x2;
            end
            FCMP_MAX: begin
                w_flag   = w_max_x1;
                w_result = w_max_x1 ? w_v_x1 : w_v_x2;
            end
            default: ;
        endcase
`ifdef FCMP_NAN_EN
        if (w_v_nan1 | w_v_nan2) begin
            if ((w_v_op == FCMP_MIN) || (w_v_op == FCMP_MAX)) begin
                w_flag   = ~w_v_nan1;
                w_result = w_v_nan1 ? (w_v_nan2 ? c_QNAN : w_v_x2) : w_v_x1;
            end else begin
                w_flag   = 1'b0;
            end
        end
`endif
        // Compare ops return the flag zero-extended as the result word.
        if (w_v_op <= FCMP_GE) begin
            w_result = {{(W-1){1'b0}}, w_flag};
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic             r_out_flag;
    logic [W-1:0]     r_out_result;
    logic [TAG_W-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_flag   <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else if (w_advance) begin
            r_out_valid  <= w_v_valid;
            r_out_flag   <= w_flag;
            r_out_result <= w_result;
            r_out_tag    <= w_v_tag;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_flag   = r_out_flag;
    assign bus.out_result = r_out_result;
    assign bus.out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_fcmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcmp_pipe
//  Description : Self-checking bench for fcmp_pipe (LATENCY 2 and 1 builds).
//                Honors FCMP_NAN_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fcmp_pipe;
    import fpu_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus2 ();
    fcmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus1 ();

    fcmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(2), .TAG_W(TAG_W)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));
    fcmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(1), .TAG_W(TAG_W)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic             flag;
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Map every word onto a signed integer line: positives keep their
    // magnitude, negatives go below zero (-0 sits just below +0).
    function automatic longint key(input logic [W-1:0] x);
        longint mag;
        mag = longint'(x[W-2:0]);
`ifdef FCMP_NAN_EN
        if (mag == 0) return 0;
`endif
        return x[W-1] ? (-mag - 1) : mag;
    endfunction

    function automatic bit is_nan(input logic [W-1:0] x);
`ifdef FCMP_NAN_EN
        return (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
`else
        return (x == '1) && 1'b0;
`endif
    endfunction

    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic f, output logic [W-1:0] r);
        longint k1, k2;
        bit n1, n2, un;
        k1 = key(a);  k2 = key(b);
        n1 = is_nan(a); n2 = is_nan(b); un = n1 | n2;
        f = 1'b0; r = '0;
        case (op)
            3'd0: f = !un && (k1 == k2);
            3'd1: f = !un && (k1 <  k2);
            3'd2: f = !un && (k1 <= k2);
            3'd3: f = !un && (k1 >= k2);
            3'd4, 3'd5: begin
                if (n1 && n2)        r = 32'h7FC0_0000;
                else if (n1)         r = b;
                else if (n2)         r = a;
                else if (k1 == k2 && a != b)   // +0 / -0 pair
                    r = (op == 3'd4) ? ((a[W-1] | b[W-1]) ? 32'h8000_0000 : 32'h0)
                                     : ((a[W-1] & b[W-1]) ? 32'h8000_0000 : 32'h0);
                else if (op == 3'd4) r = (k1 <= k2) ? a : b;
                else                 r = (k1 >= k2) ? a : b;
                f = !(n1 && n2) && (r == a) && !n1;
            end
            default: ;
        endcase
        if (op <= 3'd3) r = {{(W-1){1'b0}}, f};
    endtask

    function automatic logic [W-1:0] gen_a();
        logic [W-1:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h0000_0000;
            1: r = 32'h8000_0000;
            2: begin r[W-2 -: EXP_W] = '1; if (r[MAN_W-1:0] == '0) r[0] = 1'b1; end
            3: r = 32'h3F80_0000;
            4: r = 32'hBF80_0000;
            5: r = 32'h7F80_0000;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] gen_b(input logic [W-1:0] a);
        case ($urandom_range(0, 4))
            0: return a;
            1: return a ^ 32'h8000_0000;
            default: return gen_a();
        endcase
    endfunction

    // ---------------- directed helpers ----------------
    task automatic direct2(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TAG_W-1:0] t,
                           input logic ef, input logic [W-1:0] er);
        bus2.in_valid = 1'b1; bus2.in_op = op; bus2.in_x1 = a; bus2.in_x2 = b;
        bus2.in_tag = t; bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        chk({nm, "_not_yet"}, bus2.out_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, bus2.out_valid, 1);
        chk({nm, "_flag"},  bus2.out_flag,  ef);
        chk({nm, "_res"},   bus2.out_result, er);
        chk({nm, "_tag"},   bus2.out_tag,   t);
    endtask

    task automatic direct1(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TAG_W-1:0] t);
        logic ef; logic [W-1:0] er;
        model(op, a, b, ef, er);
        bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_x1 = a; bus1.in_x2 = b;
        bus1.in_tag = t; bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk({nm, "_valid"}, bus1.out_valid, 1);
        chk({nm, "_flag"},  bus1.out_flag,  ef);
        chk({nm, "_res"},   bus1.out_result, er);
        chk({nm, "_tag"},   bus1.out_tag,   t);
    endtask

    // Streams n ops into the LATENCY=2 unit; rnd=0 stalls cycles 3..5.
    task automatic run_stream(input int n, input bit rnd);
        int sent = 0, recv = 0, c = 0;
        logic [W-1:0] a, b, hold_r;
        logic [2:0]   op;
        logic hold_v, hold_f, stalled_prev, pend;
        logic [TAG_W-1:0] hold_t;
        logic ef; logic [W-1:0] er;
        exp_t e;
        stalled_prev = 1'b0; pend = 1'b0;
        hold_v = 1'b0; hold_f = 1'b0; hold_r = '0; hold_t = '0;
        a = gen_a(); b = gen_b(a); op = 3'($urandom_range(0, 7));
        while (recv < n && c < 20 * n + 50) begin
            bus2.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= 3 && c <= 5);
            if (!pend) pend = (sent < n) && (rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
            bus2.in_valid = pend;
            bus2.in_op = op; bus2.in_x1 = a; bus2.in_x2 = b; bus2.in_tag = TAG_W'(sent);
            #1;
            if (!rnd && c >= 3 && c <= 5) chk("stall_in_ready", bus2.in_ready, 0);
            if (stalled_prev) begin
                chk("hold_valid", bus2.out_valid,  hold_v);
                chk("hold_flag",  bus2.out_flag,   hold_f);
                chk("hold_res",   bus2.out_result, hold_r);
                chk("hold_tag",   bus2.out_tag,    hold_t);
            end
            if (bus2.out_valid && bus2.out_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("stream_flag", bus2.out_flag,   e.flag);
                    chk("stream_res",  bus2.out_result, e.res);
                    chk("stream_tag",  bus2.out_tag,    e.tag);
                end
                recv++;
            end
            if (bus2.in_valid && bus2.in_ready) begin
                model(op, a, b, ef, er);
                e.flag = ef; e.res = er; e.tag = TAG_W'(sent);
                sb.push_back(e);
                sent++; pend = 1'b0;
                a = gen_a(); b = gen_b(a); op = 3'($urandom_range(0, 7));
            end
            stalled_prev = bus2.out_valid && !bus2.out_ready;
            hold_v = bus2.out_valid; hold_f = bus2.out_flag;
            hold_r = bus2.out_result; hold_t = bus2.out_tag;
            @(posedge clk); #1;
            c++;
        end
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        chk("stream_recv", recv, n);
        chk("stream_sb_empty", sb.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_x1 = '0; bus2.in_x2 = '0;
        bus2.in_tag = '0; bus2.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_op = '0; bus1.in_x1 = '0; bus1.in_x2 = '0;
        bus1.in_tag = '0; bus1.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        chk("rst_out_valid", bus2.out_valid,  0);
        chk("rst_out_flag",  bus2.out_flag,   0);
        chk("rst_out_res",   bus2.out_result, 0);
        chk("rst_out_tag",   bus2.out_tag,    0);
        chk("rst_in_ready",  bus2.in_ready,   1);
        chk("rst1_out_valid", bus1.out_valid, 0);

        direct2("ge_1_2",   3'd3, 32'h3F80_0000, 32'h4000_0000, 5'h11, 1'b0, 32'h0);
        direct2("lt_1_2",   3'd1, 32'h3F80_0000, 32'h4000_0000, 5'h12, 1'b1, 32'h1);
        direct2("ge_n1_n2", 3'd3, 32'hBF80_0000, 32'hC000_0000, 5'h13, 1'b1, 32'h1);
        direct2("min_n1_n2",3'd4, 32'hBF80_0000, 32'hC000_0000, 5'h14, 1'b0, 32'hC000_0000);
`ifdef FCMP_NAN_EN
        direct2("eq_pz_nz", 3'd0, 32'h0000_0000, 32'h8000_0000, 5'h15, 1'b1, 32'h1);
        direct2("min_nan2", 3'd4, 32'h7FC0_0001, 32'h7F80_0005, 5'h16, 1'b0, 32'h7FC0_0000);
        direct2("min_nz_pz",3'd4, 32'h0000_0000, 32'h8000_0000, 5'h17, 1'b0, 32'h8000_0000);
`else
        direct2("eq_pz_nz", 3'd0, 32'h0000_0000, 32'h8000_0000, 5'h15, 1'b0, 32'h0);
        direct2("min_nan2", 3'd4, 32'h7FC0_0001, 32'h7F80_0005, 5'h16, 1'b0, 32'h7F80_0005);
        direct2("lt_nz_pz", 3'd1, 32'h8000_0000, 32'h0000_0000, 5'h17, 1'b1, 32'h1);
`endif
        direct2("max_pz_nz",3'd5, 32'h0000_0000, 32'h8000_0000, 5'h18, 1'b1, 32'h0);
        direct2("le_nan",   3'd2, 32'h7FC0_0001, 32'h3F80_0000, 5'h19, 1'b0, 32'h0);
        direct2("min_nan",  3'd4, 32'h7FC0_0001, 32'h3F80_0000, 5'h1A, 1'b0, 32'h3F80_0000);
        direct2("max_tie",  3'd5, 32'h4000_0000, 32'h4000_0000, 5'h1B, 1'b1, 32'h4000_0000);
        direct2("rsv_op6",  3'd6, 32'h3F80_0000, 32'h3F80_0000, 5'h1C, 1'b0, 32'h0);
        direct2("rsv_op7",  3'd7, 32'hBF80_0000, 32'h3F80_0000, 5'h1D, 1'b0, 32'h0);

        // Drain the last directed result before streaming.
        @(posedge clk); #1;

        run_stream(8, 1'b0);
        run_stream(300, 1'b1);

        // Reset with two operations in flight.
        bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1; bus2.in_op = 3'd3; bus2.in_x1 = 32'h4000_0000;
        bus2.in_x2 = 32'h3F80_0000; bus2.in_tag = 5'h05;
        @(posedge clk); #1;
        bus2.in_tag = 5'h06;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        chk("inflight_valid", bus2.out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_flush_valid", bus2.out_valid, 0);
        chk("rst_flush_ready", bus2.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_stale_result", bus2.out_valid, 0);
        end

        // Single-stage build: result one cycle after acceptance.
        direct1("l1_ge",  3'd3, 32'h3F80_0000, 32'h4000_0000, 5'h03);
        direct1("l1_min", 3'd4, 32'hBF80_0000, 32'hC000_0000, 5'h04);
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a;
            a = gen_a();
            direct1("l1_rand", 3'($urandom_range(0, 7)), a, gen_b(a), TAG_W'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
